cdb_result_buffer: RTL

Per-functional-unit result buffering and Common Data Bus (CDB) broadcast stage. Each functional unit (FU) pushes completed results into its own small FIFO. Non-empty FIFOs raise requests to the fixed-priority arbiter `ARB` (LSB highest priority). The granted FIFO head is registered onto the single CDB, which the reservation stations, ROB and register file consume.

---
 rtl/cdb_result_buffer_pkg.sv | 16 +
 rtl/cdb_arb.sv | 22 ++
 rtl/cdb_fu_fifo.sv | 74 +++++++
 rtl/cdb_result_buffer.sv | 99 +++++++++
 4 files changed

// File: rtl/cdb_result_buffer_pkg.sv
// Shared types for the CDB result buffer: arbiter width and the entry bundle
// carried through the per-FU FIFOs and out onto the broadcast bus.
package cdb_types;

  localparam int ARB_NUM    = 4;
  localparam int CDB_PREG_W = 6;
  localparam int CDB_ROB_W  = 5;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_PREG_W-1:0] pd;
    logic [CDB_ROB_W-1:0]  rob;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arb.sv
// Fixed-priority arbiter: lowest set request bit wins, grant is one-hot or zero.
module cdb_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_fu_fifo.sv
// Per-FU result FIFO. Full is derived from the registered count only, so a full
// FIFO never accepts a push in the same cycle it pops.
module cdb_fu_fifo
  import cdb_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  cdb_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output cdb_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  cdb_entry_t       mem_q [DEPTH];
  cdb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[head_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Discard everything, including any push or pop offered this cycle.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/cdb_result_buffer.sv
// Per-FU result buffering with fixed-priority arbitration onto a single
// registered Common Data Bus.
module cdb_result_buffer
  import cdb_types::*;
#(
  parameter int NUM_FU = ARB_NUM,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*PREG_W-1:0] fu_pd,
  input  logic [NUM_FU*ROB_W-1:0]  fu_rob,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic                     cdb_valid,
  output logic [PREG_W-1:0]        cdb_pd,
  output logic [ROB_W-1:0]         cdb_rob,
  output logic [DATA_W-1:0]        cdb_data
);

  cdb_entry_t        heads [NUM_FU];
  cdb_entry_t        sel_entry;
  logic [NUM_FU-1:0] full, empty, req, grant;

  cdb_entry_t cdb_q, cdb_d;
  logic       cdb_valid_q, cdb_valid_d;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    cdb_entry_t push_entry;

    assign push_entry.pd   = fu_pd[g*PREG_W +: PREG_W];
    assign push_entry.rob  = fu_rob[g*ROB_W +: ROB_W];
    assign push_entry.data = fu_data[g*DATA_W +: DATA_W];

    cdb_fu_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (fu_valid[g]),
      .push_entry(push_entry),
      .pop       (grant[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .head      (heads[g])
    );
  end

  assign fu_ready = ~full;
  assign req      = ~empty;

  cdb_arb #(
    .N(NUM_FU)
  ) u_arb (
    .req  (req),
    .grant(grant)
  );

  // Grant is one-hot or zero, so an OR-reduction acts as the head mux.
  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        sel_entry = sel_entry | heads[i];
      end
    end
  end

  always_comb begin
    cdb_d       = cdb_q;
    cdb_valid_d = 1'b0;
    if (!flush && (|grant)) begin
      cdb_valid_d = 1'b1;
      cdb_d       = sel_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_pd    = cdb_q.pd;
  assign cdb_rob   = cdb_q.rob;
  assign cdb_data  = cdb_q.data;

endmodule
